// File: rtl/cyq_bcd_scan_pkg.sv
// Shared types and constants for the cyq_bcd_scan counter/scanner slice.
// Holds the decade limits, the digit nibble type and the scan state encoding.
package cyq_pkg;
   localparam int         NDIG    = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } scan_t;

   // Out-of-range load nibbles clamp to 9 so the counter never holds a non-decimal digit.
   function automatic bcd_t bcd_sat(input bcd_t v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction

   function automatic logic [3:0] sel_of(input scan_t s);
      return ~(4'b0001 << s);
   endfunction
endpackage

// File: rtl/cyq_bcd_scan_if.sv
// Control/display bundle of cyq_bcd_scan. The master drives count controls,
// the slave (the counter) returns the count, wrap pulse, strobes and digit data.
interface cyq_bcd_scan_if;
   import cyq_pkg::*;

   logic        cnt_en;
   logic        up_dn;
   logic        load;
   logic [15:0] load_val;
   logic [15:0] cnt;
   logic        carry;
   logic [3:0]  dig_sel;
   bcd_t        bcd;
   logic        bi;
   scan_t       scan_state;

   modport master (
      output cnt_en, up_dn, load, load_val,
      input  cnt, carry, dig_sel, bcd, bi, scan_state
   );

   modport slave (
      input  cnt_en, up_dn, load, load_val,
      output cnt, carry, dig_sel, bcd, bi, scan_state
   );
endinterface

// File: rtl/cyq_bcd_scan_digit.sv
// One BCD decade: load, hold or step up/down, with a combinational ripple
// to the next decade when this digit wraps in the current step.
module cyq_bcd_digit
   import cyq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  bcd_t ld_val,
   input  logic step_in,
   input  logic up_dn,
   output bcd_t q,
   output logic step_out
);

   bcd_t r_q;
   logic w_term;

   assign w_term   = up_dn ? (r_q == BCD_MAX) : (r_q == 4'd0);
   assign step_out = step_in & w_term;
   assign q        = r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= bcd_sat(ld_val);
      end else if (step_in) begin
         if (up_dn) r_q <= w_term ? 4'd0 : r_q + 4'd1;
         else       r_q <= w_term ? BCD_MAX : r_q - 4'd1;
      end
   end

endmodule

// File: rtl/cyq_bcd_scan.sv
// 4-digit BCD up/down counter with a multiplexed digit scanner for a 4511 decoder.
// Define CYQ_BCD_SCAN_LZB_EN to blank leading zeros through bi.
module cyq_bcd_scan
   import cyq_pkg::*;
#(
   parameter int SCAN_DIV = 4,
   parameter int PRE_W    = 8
) (
   input  logic           clk,
   input  logic           rst,
   cyq_bcd_scan_if.slave  bus
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

   logic [NDIG*4-1:0] w_cnt;
   logic [NDIG:0]     w_step;
   logic              r_carry;

   assign w_step[0] = bus.cnt_en;

   for (genvar g = 0; g < NDIG; g++) begin : g_dig
      cyq_bcd_digit u_dig (
         .clk      (clk),
         .rst      (rst),
         .load     (bus.load),
         .ld_val   (bus.load_val[4*g +: 4]),
         .step_in  (w_step[g]),
         .up_dn    (bus.up_dn),
         .q        (w_cnt[4*g +: 4]),
         .step_out (w_step[g+1])
      );
   end

   // A ripple out of the top decade is the wrap; loads never report one.
   always_ff @(posedge clk) begin
      if (rst)           r_carry <= 1'b0;
      else if (bus.load) r_carry <= 1'b0;
      else               r_carry <= w_step[NDIG];
   end

   scan_t            r_state, w_state_nx;
   logic [PRE_W-1:0] r_pre, w_pre_nx;
   logic [3:0]       r_dig_sel, w_dig_sel_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S0;
         r_pre     <= '0;
         r_dig_sel <= 4'b1110;
      end else begin
         r_state   <= w_state_nx;
         r_pre     <= w_pre_nx;
         r_dig_sel <= w_dig_sel_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_pre_nx   = r_pre + PRE_W'(1);
      if (r_pre == PRE_LAST) begin
         w_pre_nx = '0;
         case (r_state)
            S0:      w_state_nx = S1;
            S1:      w_state_nx = S2;
            S2:      w_state_nx = S3;
            S3:      w_state_nx = S0;
            default: w_state_nx = S0;
         endcase
      end
      w_dig_sel_nx = sel_of(w_state_nx);
   end

   bcd_t w_bcd;
   logic w_bi;

   always_comb begin
      w_bcd = '0;
      case (r_state)
         S0:      w_bcd = w_cnt[3:0];
         S1:      w_bcd = w_cnt[7:4];
         S2:      w_bcd = w_cnt[11:8];
         S3:      w_bcd = w_cnt[15:12];
         default: w_bcd = '0;
      endcase
   end

`ifdef CYQ_BCD_SCAN_LZB_EN
   // w_hi_zero[i]: nibbles i..3 are all zero, i.e. digit i is a leading zero.
   logic [NDIG-1:0] w_hi_zero;
   assign w_hi_zero[3] = (w_cnt[15:12] == 4'd0);
   assign w_hi_zero[2] = w_hi_zero[3] & (w_cnt[11:8] == 4'd0);
   assign w_hi_zero[1] = w_hi_zero[2] & (w_cnt[7:4] == 4'd0);
   assign w_hi_zero[0] = w_hi_zero[1] & (w_cnt[3:0] == 4'd0);
   assign w_bi = ~((r_state != S0) & w_hi_zero[r_state]);
`else
   assign w_bi = 1'b1;
`endif

   assign bus.cnt        = w_cnt;
   assign bus.carry      = r_carry;
   assign bus.dig_sel    = r_dig_sel;
   assign bus.bcd        = w_bcd;
   assign bus.bi         = w_bi;
   assign bus.scan_state = r_state;

endmodule

// File: doc/cyq_bcd_scan.md
Name: cyq_bcd_scan

Overview:
- 4-digit synchronous BCD up/down counter with a time-multiplexed display scanner.
- Sits directly upstream of cyq_74HC4511. `bcd` drives the decoder D[3:0]. `bi` drives its BI input.
- `dig_sel` drives the common-cathode digit strobes (active-low).
- Gives the combinational decode path a sequential source of digit data.

Parameters:
- SCAN_DIV, 4: clock cycles each digit stays selected. Legal range 1..255.
- PRE_W, 8: prescaler counter width. Must satisfy 2**PRE_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- cnt_en  input  1  count enable; one BCD step per cycle while high.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load; priority over cnt_en.
- load_val  input  16  4 packed BCD nibbles; [3:0] = digit 0 (units).
- cnt  output  16  current count, packed BCD.
- carry  output  1  one-cycle wrap pulse (9999->0000 up, or 0000->9999 down).
- dig_sel  output  4  active-low one-hot digit strobe; bit i selects digit i.
- bcd  output  4  nibble of the currently selected digit.
- bi  output  1  blanking to the 4511 (active-low; 0 = blank).

Behaviour:
- Clocking: one clock domain; reset is synchronous and active-high.
- Reset values (one rising edge with rst=1), all outputs and state:
  - cnt = 16'h0000, carry = 0, prescaler = 0, scan index = 0.
  - dig_sel = 4'b1110, bcd = 4'h0, bi = 1.
  - rst overrides load and cnt_en.
  - Reset mid-scan or mid-count takes effect on the same edge; no partial state survives.
- Count priority per edge: rst > load > cnt_en > hold.
- Load:
  - cnt <= load_val, except any nibble > 9 is saturated to 9.
  - carry <= 0.
- Up step:
  - Digit 0 increments. A digit at 9 becomes 0 and ripples +1 into the next digit, within the same cycle.
  - 9999 -> 0000 with carry = 1 on the edge where cnt becomes 0000.
- Down step:
  - Digit 0 decrements. A digit at 0 becomes 9 and ripples a borrow, within the same cycle.
  - 0000 -> 9999 with carry = 1.
- carry:
  - Registered; high for exactly one cycle per wrap.
  - Back-to-back wraps give back-to-back pulses.
  - 0 in any cycle without a wrap.
- Latency: cnt reflects load or step one edge after the input is sampled.
- Scan state machine (states S0..S3 = selected digit):
  - Prescaler counts 0..SCAN_DIV-1, then returns to 0.
  - When the prescaler equals SCAN_DIV-1, the state advances S0->S1->S2->S3->S0.
  - SCAN_DIV = 1 advances every cycle.
  - Scanning runs continuously, independent of cnt_en, load and up_dn.
- Output timing:
  - dig_sel and the state are registered.
  - bcd = nibble of the current cnt for the selected digit; combinational from registers, same cycle as dig_sel.
  - A cnt change while a digit is selected appears on bcd in the next cycle.

Optional Feature:
- Macro: CYQ_BCD_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - bi = 0 while the selected digit i > 0 and nibbles i..3 of cnt are all zero.
  - Digit 0 is never blanked. Example: cnt = 0040 gives digits 3 and 2 blank, digits 1 and 0 shown.
  - bi is combinational from the same registers as bcd.
- Not defined: bi is tied to 1.

Decomposition:
- Package cyq_pkg:
  - NDIG = 4, BCD_MAX = 4'd9.
  - typedef bcd_t (logic [3:0]).
  - typedef scan_t (enum S0..S3).
- Sub-module cyq_bcd_digit: one decade.
  - Ports: clk, rst, load, ld_val, step_in, up_dn, q, step_out.
  - Instantiated NDIG times; step_out chains to the next digit's step_in.
  - carry = registered step_out of digit 3.

Test Plan:
- Reset scan: rst=1 for 2 cycles -> cnt=0000, dig_sel=1110, bcd=0, carry=0. Release with SCAN_DIV=4 -> dig_sel 1110 for cycles 0-3, 1101 for cycles 4-7, then 1011, 0111, back to 1110 at cycle 16.
- Up ripple and wrap: load 9998, then cnt_en=1, up_dn=1 for 3 cycles -> cnt 9999, 0000 (carry=1 that cycle only), 0001 (carry=0).
- Down borrow: load 0100, then one down step -> 0099, carry=0. Load 0000, then one down step -> 9999, carry=1.
- Priority and saturation: load_val=16'hAB3F with load=1 and cnt_en=1 -> cnt=9939, carry=0. rst=1 together with load=1 -> cnt=0000.
- Scan data path: cnt=1234 held, SCAN_DIV=1 -> bcd sequence 4,3,2,1 with dig_sel 1110, 1101, 1011, 0111.
- LZB (macro defined): cnt=0040 -> bi = 1,1,0,0 for digits 0..3. cnt=0000 -> bi = 1 on digit 0 only. Macro undefined -> bi always 1.
